dma_multichan: RTL and testbench
================================

# dma_multichan

Parametrised multi-channel DMA engine: the next generation of the single-buffer DMA. Each of `CHANNELS` I/O channels streams words through its own FIFO into a programmed memory block. A cycle-stealing arbiter shares the single memory port with the processor (pc) path and includes a starvation guard that briefly stalls the CPU. It sits between the CPU/I-O sources and the data memory, in place of the former bus mux.

## Interface
Parameters:
- `DATA_W`, 32, data width.
- `ADDR_W`, 32, memory address width (word addressing).
- `CHANNELS`, 2, number of I/O channels (1..8).
- `FIFO_DEPTH`, 4, words per channel FIFO (power of two, ≥2).
- `LEN_W`, 8, transfer-length counter width.
- `STARVE_LIM`, 8, consecutive denied cycles with a full FIFO before a forced grant.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_we` in 1: program channel `cfg_ch` this cycle.
- `cfg_ch` in $clog2(CHANNELS): channel index.
- `cfg_base` in ADDR_W: block base address.
- `cfg_len` in LEN_W: words to transfer.
- `io_valid` in CHANNELS: per-channel word valid.
- `io_data` in CHANNELS*DATA_W: packed words, channel c at [c*DATA_W +: DATA_W].
- `io_ready` out CHANNELS: per-channel accept.
- `cpu_addr` in ADDR_W, `cpu_wdata` in DATA_W, `cpu_rd` in 1, `cpu_wr` in 1: processor bus request.
- `cpu_stall` out 1: CPU access not performed this cycle; CPU holds its request.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_rd` out 1, `mem_wr` out 1: memory port.
- `busy` out CHANNELS: channel programmed and not finished.
- `done` out CHANNELS: one-cycle completion pulse.

## Operation
- **Programming.** `cfg_we` with `busy[cfg_ch]`=0 loads base and len, clears the channel's received count (rc) and written count (wc), and sets busy.
  - `cfg_we` to a busy channel is ignored.
  - `cfg_ch` ≥ CHANNELS is ignored.
  - `cfg_len`=0: busy stays 0 and `done[cfg_ch]` pulses the next cycle. No memory writes occur.
- **Intake.** `io_ready[c]` = busy[c] & FIFO c not full & rc < len.
  - A transfer occurs when `io_valid[c]` and `io_ready[c]` are both high. The word is pushed into FIFO c and rc increments.
- **Arbitration.** The DMA requests the port when any FIFO is non-empty.
  - CPU priority: the DMA is granted only when `cpu_rd`=`cpu_wr`=0, or when a starvation force is active.
  - Starvation counter: increments each cycle in which some FIFO is full, the DMA is requesting, and the DMA is not granted. It clears on any DMA grant. When it reaches STARVE_LIM, the next cycle is a forced grant.
  - During a forced grant, `cpu_stall`=1 only if the CPU is requesting. `cpu_stall` is never asserted in any other case.
- **Channel select.** On a grant, the channel is chosen round-robin among non-empty FIFOs, starting after the last channel serviced.
- **DMA write.** `mem_wr`=1, `mem_rd`=0, `mem_addr` = base + wc (modulo 2^ADDR_W), `mem_wdata` = FIFO head. The FIFO pops and wc increments.
- **No grant.** `mem_*` mirror the `cpu_*` inputs combinationally.
- **Completion.** When wc reaches len, busy clears and `done[c]` pulses one cycle later. The channel can then be reprogrammed.
- **Reset.** Asserting `rst_n` low, including mid-transfer, empties all FIFOs, clears counters, busy, done, the starvation counter and the round-robin pointer. No partial-block recovery is performed.

## Timing
- Reset values: `io_ready`=0, `busy`=0, `done`=0, `cpu_stall`=0. `mem_*` equal the `cpu_*` inputs.
- Programming latency: `busy` rises and `io_ready` can assert in the cycle after `cfg_we`.
- FIFO latency: a word accepted in cycle N is eligible for the memory port in cycle N+1, not earlier.
- The grant, channel select and `mem_*`/`cpu_stall` are combinational from registered state and the current `cpu_rd`/`cpu_wr`. All counters and FIFOs update on the clock edge.
- Throughput: at most one DMA write per cycle across all channels, and one push per channel per cycle.
- A push and a pop on the same FIFO in the same cycle are both performed, so occupancy is unchanged. This also applies when the FIFO is full, because the pop frees a slot, and `io_ready` accounts for it.
- `done` is asserted for exactly one cycle, the cycle after the final write's clock edge.

## Test plan
- **Single channel, CPU idle.** ch0 base 0x100, len 3; words A, B, C on consecutive cycles -> writes 0x100=A, 0x101=B, 0x102=C in cycles 2-4 after the first word; `done[0]` one cycle after the last write; 4th `io_valid` gets `io_ready`=0.
- **CPU contention.** ch0 len 4 with `cpu_rd` held high for 3 cycles -> mem mirrors the CPU for 3 cycles, `cpu_stall`=0, then the DMA drains.
- **Starvation.** FIFO_DEPTH 4, STARVE_LIM 8, CPU requesting continuously, ch0 fills -> after 8 full denied cycles exactly one DMA write with `cpu_stall`=1, then CPU resumes.
- **Two channels, round robin.** Both FIFOs non-empty with CPU idle -> writes alternate ch0, ch1, ch0, ch1 to their respective bases.
- **Edge programming.** len 0 -> `done` pulse next cycle and no `mem_wr`; reprogramming a busy channel -> ignored, base unchanged; base 0xFFFFFFFF with len 2 -> addresses 0xFFFFFFFF then 0x0.
- **Reset mid-transfer.** Assert `rst_n` low after 2 of 4 words -> `busy`=0, `io_ready`=0, no further `mem_wr`; after release, reprogram and complete normally.

Source files
------------

// File: rtl/dma_multichan.sv
// dma_multichan: multi-channel DMA that shares one memory port with the CPU by cycle stealing.
// Latency: a word accepted from I/O is writable one cycle later; grant/mem_* are combinational.
// Backpressure: io_ready drops on full FIFO or exhausted length; CPU stalls only on a starvation-forced grant.
//
// Ports: clk/rst_n (async active-low); cfg_* program a channel (base, len);
//   io_valid/io_data/io_ready per-channel word intake; cpu_* processor bus request,
//   cpu_stall when the CPU access is displaced; mem_* shared memory port;
//   busy per channel while a block is outstanding; done one-cycle completion pulse.

// Generic synchronous FIFO with simultaneous push/pop, including push into a full FIFO
// when the same cycle pops. Output is the registered head (no bypass).
module dma_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dat_o   = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= dat_i;
  end
endmodule

module dma_multichan #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8,
  parameter int STARVE_LIM = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    cfg_ch,
  input  logic [ADDR_W-1:0]                                     cfg_base,
  input  logic [LEN_W-1:0]                                      cfg_len,
  input  logic [CHANNELS-1:0]                                   io_valid,
  input  logic [CHANNELS*DATA_W-1:0]                            io_data,
  output logic [CHANNELS-1:0]                                   io_ready,
  input  logic [ADDR_W-1:0]                                     cpu_addr,
  input  logic [DATA_W-1:0]                                     cpu_wdata,
  input  logic                                                  cpu_rd,
  input  logic                                                  cpu_wr,
  output logic                                                  cpu_stall,
  output logic [ADDR_W-1:0]                                     mem_addr,
  output logic [DATA_W-1:0]                                     mem_wdata,
  output logic                                                  mem_rd,
  output logic                                                  mem_wr,
  output logic [CHANNELS-1:0]                                   busy,
  output logic [CHANNELS-1:0]                                   done
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SC_W = $clog2(STARVE_LIM + 1);

  // Per-channel programming and progress state.
  logic [ADDR_W-1:0]   base_q [CHANNELS];
  logic [LEN_W-1:0]    len_q  [CHANNELS];
  logic [LEN_W-1:0]    rc_q   [CHANNELS];
  logic [LEN_W-1:0]    wc_q   [CHANNELS];
  logic [CHANNELS-1:0] busy_q, done_q;

  logic [SC_W-1:0]     starve_q, starve_d;
  logic [CH_W-1:0]     rr_q, rr_d;

  logic [CHANNELS-1:0] f_full, f_empty, f_push, f_pop, cfg_hit;
  logic [DATA_W-1:0]   f_head [CHANNELS];

  logic                dma_req, cpu_req, force_grant, grant, found;
  logic [CH_W-1:0]     sel;
  logic [CH_W:0]       cand, nxt;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    dma_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (f_push[c]),
      .dat_i   (io_data[c*DATA_W +: DATA_W]),
      .pop_i   (f_pop[c]),
      .dat_o   (f_head[c]),
      .full_o  (f_full[c]),
      .empty_o (f_empty[c])
    );

    // Out-of-range channel indices never match any c, so they are dropped here.
    assign cfg_hit[c]  = cfg_we && (cfg_ch == CH_W'(c)) && !busy_q[c];
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign io_ready[c] = busy_q[c] && (!f_full[c] || f_pop[c]) && (rc_q[c] < len_q[c]);
    assign f_push[c]   = io_valid[c] && io_ready[c];
  end

  // Arbitration, round-robin select and memory port steering.
  always_comb begin
    dma_req     = |(~f_empty);
    cpu_req     = cpu_rd | cpu_wr;
    force_grant = dma_req && (starve_q >= SC_W'(STARVE_LIM));
    grant       = dma_req && (!cpu_req || force_grant);

    // Search starts at rr_q, which holds the channel after the last one serviced.
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, rr_q} + (CH_W+1)'(i);
      if (cand >= (CH_W+1)'(CHANNELS)) cand = cand - (CH_W+1)'(CHANNELS);
      if (!found && !f_empty[cand[CH_W-1:0]]) begin
        sel   = cand[CH_W-1:0];
        found = 1'b1;
      end
    end

    f_pop = '0;
    if (grant) f_pop[sel] = 1'b1;

    nxt = {1'b0, sel} + 1'b1;
    if (nxt >= (CH_W+1)'(CHANNELS)) nxt = '0;
    rr_d = grant ? nxt[CH_W-1:0] : rr_q;

    if (grant)                       starve_d = '0;
    else if (dma_req && |f_full)     starve_d = starve_q + 1'b1;
    else                             starve_d = starve_q;

    cpu_stall = grant && force_grant && cpu_req;

    if (grant) begin
      mem_addr  = base_q[sel] + ADDR_W'(wc_q[sel]);
      mem_wdata = f_head[sel];
      mem_rd    = 1'b0;
      mem_wr    = 1'b1;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      rr_q     <= '0;
    end else begin
      starve_q <= starve_d;
      rr_q     <= rr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      done_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        base_q[c] <= '0;
        len_q[c]  <= '0;
        rc_q[c]   <= '0;
        wc_q[c]   <= '0;
      end
    end else begin
      done_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_hit[c]) begin
          // Zero-length block completes immediately without going busy.
          if (cfg_len == '0) begin
            done_q[c] <= 1'b1;
          end else begin
            base_q[c] <= cfg_base;
            len_q[c]  <= cfg_len;
            rc_q[c]   <= '0;
            wc_q[c]   <= '0;
            busy_q[c] <= 1'b1;
          end
        end else begin
          if (f_push[c]) rc_q[c] <= rc_q[c] + 1'b1;
          if (f_pop[c]) begin
            wc_q[c] <= wc_q[c] + 1'b1;
            if (wc_q[c] + 1'b1 == len_q[c]) begin
              busy_q[c] <= 1'b0;
              done_q[c] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_dma_multichan.sv
// Bench for dma_multichan: directed scenarios followed by randomized traffic.
// Intake pushes expected memory writes into per-channel queues; the monitor pops on DMA writes.
// Arbitration expectation is derived from queue occupancy, starvation count and a rotating start.
module tb_dma_multichan;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int CH  = 3;
  localparam int FD  = 4;
  localparam int LW  = 8;
  localparam int SL  = 8;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [CHW-1:0]    cfg_ch;
  logic [AW-1:0]     cfg_base;
  logic [LW-1:0]     cfg_len;
  logic [CH-1:0]     io_valid;
  logic [CH*DW-1:0]  io_data;
  logic [CH-1:0]     io_ready;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_rd, cpu_wr, cpu_stall;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_rd, mem_wr;
  logic [CH-1:0]     busy, done;

  always #5 clk = ~clk;

  dma_multichan #(
    .DATA_W(DW), .ADDR_W(AW), .CHANNELS(CH), .FIFO_DEPTH(FD), .LEN_W(LW), .STARVE_LIM(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .io_valid(io_valid), .io_data(io_data), .io_ready(io_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  // Reference model state (written only by the monitor).
  wr_t           exp_q [CH][$];
  logic [AW-1:0] m_base [CH];
  int            m_len [CH];
  int            m_rc [CH];
  int            m_wc [CH];
  logic [CH-1:0] m_busy, m_done, m_rdy, busy_snap;
  int            m_starve, m_rr, m_sel, idx;
  bit            m_req, m_full, m_force, m_grant, m_cpu;
  wr_t           w;
  int            n_cmp, n_err, n_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        exp_q[c].delete();
        m_rc[c] = 0; m_wc[c] = 0; m_len[c] = 0; m_base[c] = '0;
      end
      m_busy = '0; m_done = '0; m_starve = 0; m_rr = 0;
      chk("rst_io_ready", 64'(io_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_cpu_stall", 64'(cpu_stall), 64'(0));
      chk("rst_mem_mirror", {mem_addr, mem_rd, mem_wr}, {cpu_addr, cpu_rd, cpu_wr});
    end else begin
      m_cpu = cpu_rd | cpu_wr;
      m_req = 0; m_full = 0;
      for (int c = 0; c < CH; c++) begin
        if (exp_q[c].size() > 0) m_req = 1;
        if (exp_q[c].size() == FD) m_full = 1;
      end
      m_force = m_req && (m_starve >= SL);
      m_grant = m_req && (!m_cpu || m_force);
      m_sel = -1;
      for (int i = 0; i < CH; i++) begin
        idx = (m_rr + i) % CH;
        if (m_sel < 0 && exp_q[idx].size() > 0) m_sel = idx;
      end
      for (int c = 0; c < CH; c++)
        m_rdy[c] = m_busy[c] && (exp_q[c].size() < FD || (m_grant && m_sel == c)) && (m_rc[c] < m_len[c]);

      chk("io_ready", 64'(io_ready), 64'(m_rdy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("cpu_stall", 64'(cpu_stall), 64'(m_grant && m_force && m_cpu));

      busy_snap = m_busy;
      m_done = '0;
      if (m_grant) begin
        w = exp_q[m_sel].pop_front();
        n_wr++;
        chk("dma_wr_rd", {62'd0, mem_wr, mem_rd}, 64'b10);
        chk("dma_addr", 64'(mem_addr), 64'(w.addr));
        chk("dma_data", 64'(mem_wdata), 64'(w.dat));
        m_wc[m_sel]++;
        if (m_wc[m_sel] == m_len[m_sel]) begin
          m_busy[m_sel] = 1'b0;
          m_done[m_sel] = 1'b1;
        end
        m_rr = (m_sel + 1) % CH;
        m_starve = 0;
      end else begin
        chk("cpu_mirror", {mem_addr, mem_rd, mem_wr}, {cpu_addr, cpu_rd, cpu_wr});
        chk("cpu_mirror_wdata", 64'(mem_wdata), 64'(cpu_wdata));
        if (m_req && m_full) m_starve++;
      end

      for (int c = 0; c < CH; c++) begin
        if (io_valid[c] && m_rdy[c]) begin
          w.addr = m_base[c] + AW'(m_rc[c]);
          w.dat  = io_data[c*DW +: DW];
          exp_q[c].push_back(w);
          m_rc[c]++;
        end
      end

      if (cfg_we && int'(cfg_ch) < CH && !busy_snap[cfg_ch]) begin
        if (cfg_len == 0) begin
          m_done[cfg_ch] = 1'b1;
        end else begin
          m_base[cfg_ch] = cfg_base;
          m_len[cfg_ch]  = int'(cfg_len);
          m_rc[cfg_ch]   = 0;
          m_wc[cfg_ch]   = 0;
          m_busy[cfg_ch] = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic program_ch(input int ch, input logic [AW-1:0] base, input int len);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_base = base; cfg_len = LW'(len);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic set_word(input int ch, input logic v);
    io_valid[ch] = v;
    io_data[ch*DW +: DW] = $urandom;
  endtask

  // Waits for the model to retire all programmed blocks; bounded so the run always ends.
  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim; k++) begin
      if (m_busy == '0) break;
      cyc();
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_wr = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_base = '0; cfg_len = '0;
    io_valid = '0; io_data = '0; cpu_addr = 32'h55; cpu_wdata = 32'hA5A5; cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Single channel, CPU idle; the fourth word must be refused.
    program_ch(0, 32'h100, 3);
    for (int i = 0; i < 4; i++) begin set_word(0, 1'b1); cyc(); end
    set_word(0, 1'b0);
    wait_idle(50);
    repeat (2) cyc();

    // CPU contention for three cycles.
    program_ch(0, 32'h200, 4);
    cpu_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) cpu_rd = 1'b0;
      cpu_addr = $urandom; set_word(0, 1'b1); cyc();
    end
    set_word(0, 1'b0);
    wait_idle(50);
    repeat (2) cyc();

    // Starvation: CPU requests continuously while channel 0 streams.
    program_ch(0, 32'h300, 20);
    cpu_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin cpu_addr = $urandom; set_word(0, 1'b1); cyc(); end
    cpu_rd = 1'b0;
    for (int i = 0; i < 30 && m_busy[0]; i++) begin set_word(0, 1'b1); cyc(); end
    set_word(0, 1'b0);
    wait_idle(50);
    repeat (2) cyc();

    // Round robin: fill two channels behind the CPU, then release the port.
    program_ch(0, 32'h400, 4);
    program_ch(1, 32'h500, 4);
    cpu_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin set_word(0, 1'b1); set_word(1, 1'b1); cyc(); end
    set_word(0, 1'b0); set_word(1, 1'b0);
    cpu_wr = 1'b0;
    wait_idle(50);
    repeat (2) cyc();

    // Edge programming: zero length, busy reprogram, out-of-range channel, address wrap.
    program_ch(2, 32'h600, 0);
    cyc();
    program_ch(0, 32'h700, 3);
    program_ch(0, 32'h800, 3);
    program_ch(3, 32'h900, 2);
    for (int i = 0; i < 3; i++) begin set_word(0, 1'b1); cyc(); end
    set_word(0, 1'b0);
    wait_idle(50);
    program_ch(1, 32'hFFFF_FFFF, 2);
    for (int i = 0; i < 2; i++) begin set_word(1, 1'b1); cyc(); end
    set_word(1, 1'b0);
    wait_idle(50);
    repeat (2) cyc();

    // Reset mid-transfer, then reprogram and complete.
    program_ch(0, 32'hA00, 4);
    cpu_rd = 1'b1;
    for (int i = 0; i < 2; i++) begin set_word(0, 1'b1); cyc(); end
    set_word(0, 1'b0);
    rst_n = 1'b0;
    repeat (2) cyc();
    cpu_rd = 1'b0;
    rst_n = 1'b1;
    cyc();
    program_ch(0, 32'hB00, 4);
    for (int i = 0; i < 4; i++) begin set_word(0, 1'b1); cyc(); end
    set_word(0, 1'b0);
    wait_idle(50);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_ch   = CHW'($urandom_range(0, 3));
      cfg_base = $urandom;
      cfg_len  = LW'($urandom_range(0, 12));
      for (int c = 0; c < CH; c++) set_word(c, ($urandom_range(0, 2) != 0));
      cpu_rd    = ($urandom_range(0, 2) == 0);
      cpu_wr    = !cpu_rd && ($urandom_range(0, 3) == 0);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cyc();
    end
    cfg_we = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    for (int k = 0; k < 200 && m_busy != '0; k++) begin
      for (int c = 0; c < CH; c++) set_word(c, 1'b1);
      cyc();
    end
    io_valid = '0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
